// File: rtl/imm_gen_pkg.sv
// Shared definitions for the pipelined immediate generator: format codes,
// RV32I/RV64I major opcodes and the skid-buffer occupancy states.
package imm_gen_pkg;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_Z    = 3'd6
   } fmt_e;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_REG32  = 7'b0111011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_TWO   = 2'd2
   } skid_e;

endpackage

// File: rtl/imm_gen_decode.sv
// Combinational immediate decoder: raw instruction -> sign-extended
// immediate, format code and illegal flag.
// Optional macro IMM_GEN_PIPE_ZIMM_EN enables CSR zimm (FMT_Z) decoding of
// the SYSTEM opcode; without it every SYSTEM encoding is reported illegal.
module imm_gen_decode
   import imm_gen_pkg::*;
#(
   parameter int XLEN         = 64,
   parameter int BYTE_OFFSETS = 0
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      fmt,
   output logic            illegal
);

   logic signed [11:0]     fld_i;
   logic signed [11:0]     fld_s;
   logic signed [11:0]     fld_b;
   logic signed [12:0]     fld_b_byte;
   logic signed [19:0]     fld_j;
   logic signed [20:0]     fld_j_byte;
   logic signed [31:0]     fld_u;
   logic signed [XLEN-1:0] imm_b;
   logic signed [XLEN-1:0] imm_j;
   logic signed [XLEN-1:0] imm_d;
   fmt_e                   fmt_d;

   assign fld_i      = instr[31:20];
   assign fld_s      = {instr[31:25], instr[11:7]};
   assign fld_b      = {instr[31], instr[7], instr[30:25], instr[11:8]};
   assign fld_b_byte = {fld_b, 1'b0};
   assign fld_j      = {instr[31], instr[19:12], instr[20], instr[30:21]};
   assign fld_j_byte = {fld_j, 1'b0};
   assign fld_u      = {instr[31:12], 12'b0};

   // B/J offsets are either halfword counts or byte offsets with bit0 clear
   assign imm_b = (BYTE_OFFSETS != 0) ? XLEN'(fld_b_byte) : XLEN'(fld_b);
   assign imm_j = (BYTE_OFFSETS != 0) ? XLEN'(fld_j_byte) : XLEN'(fld_j);

   // Select immediate and format from the major opcode
   always_comb begin
      imm_d   = '0;
      fmt_d   = FMT_NONE;
      illegal = 1'b0;
      case (instr[6:0])
         OP_IMM, OP_LOAD, OP_JALR, OP_IMM32: begin
            imm_d = XLEN'(fld_i);
            fmt_d = FMT_I;
         end
         OP_STORE: begin
            imm_d = XLEN'(fld_s);
            fmt_d = FMT_S;
         end
         OP_BRANCH: begin
            imm_d = imm_b;
            fmt_d = FMT_B;
         end
         OP_LUI, OP_AUIPC: begin
            imm_d = XLEN'(fld_u);
            fmt_d = FMT_U;
         end
         OP_JAL: begin
            imm_d = imm_j;
            fmt_d = FMT_J;
         end
         OP_REG, OP_REG32: begin
            imm_d = '0;
         end
         OP_SYSTEM: begin
`ifdef IMM_GEN_PIPE_ZIMM_EN
            if (instr[14]) begin
               imm_d = XLEN'(instr[19:15]);
               fmt_d = FMT_Z;
            end else begin
               imm_d = XLEN'(fld_i);
               fmt_d = FMT_I;
            end
`else
            illegal = 1'b1;
`endif
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

   assign imm = imm_d;
   assign fmt = fmt_d;

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes each accepted instruction and
// registers the result behind a valid/ready handshake with a 2-entry skid
// buffer (output register + one skid entry). in_ready is registered and
// depends only on skid occupancy. Optional macro IMM_GEN_PIPE_ZIMM_EN is
// forwarded to the decoder.
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN         = 64,
   parameter int TAG_W        = 64,
   parameter int BYTE_OFFSETS = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic             out_illegal,
   output logic [TAG_W-1:0] out_tag
);

   logic [XLEN-1:0]  dec_imm;
   logic [2:0]       dec_fmt;
   logic             dec_illegal;

   skid_e            state;
   logic [XLEN-1:0]  skid_imm;
   logic [2:0]       skid_fmt;
   logic             skid_illegal;
   logic [TAG_W-1:0] skid_tag;

   logic             in_fire;
   logic             out_fire;

   imm_gen_decode #(
      .XLEN        (XLEN),
      .BYTE_OFFSETS(BYTE_OFFSETS)
   ) u_decode (
      .instr  (in_instr),
      .imm    (dec_imm),
      .fmt    (dec_fmt),
      .illegal(dec_illegal)
   );

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   // Skid-buffer occupancy FSM with registered handshake and data outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= SKID_EMPTY;
         in_ready     <= 1'b1;
         out_valid    <= 1'b0;
         out_imm      <= '0;
         out_fmt      <= FMT_NONE;
         out_illegal  <= 1'b0;
         out_tag      <= '0;
         skid_imm     <= '0;
         skid_fmt     <= FMT_NONE;
         skid_illegal <= 1'b0;
         skid_tag     <= '0;
      end else begin
         case (state)
            SKID_EMPTY: begin
               if (in_fire) begin
                  out_imm     <= dec_imm;
                  out_fmt     <= dec_fmt;
                  out_illegal <= dec_illegal;
                  out_tag     <= in_tag;
                  out_valid   <= 1'b1;
                  state       <= SKID_ONE;
               end
            end
            SKID_ONE: begin
               if (in_fire && !out_fire) begin
                  // Output is stalled: park the new entry in the skid slot
                  skid_imm     <= dec_imm;
                  skid_fmt     <= dec_fmt;
                  skid_illegal <= dec_illegal;
                  skid_tag     <= in_tag;
                  in_ready     <= 1'b0;
                  state        <= SKID_TWO;
               end else if (in_fire && out_fire) begin
                  out_imm     <= dec_imm;
                  out_fmt     <= dec_fmt;
                  out_illegal <= dec_illegal;
                  out_tag     <= in_tag;
               end else if (out_fire) begin
                  out_valid <= 1'b0;
                  state     <= SKID_EMPTY;
               end
            end
            SKID_TWO: begin
               // in_ready is low here, so only the output can move
               if (out_fire) begin
                  out_imm     <= skid_imm;
                  out_fmt     <= skid_fmt;
                  out_illegal <= skid_illegal;
                  out_tag     <= skid_tag;
                  in_ready    <= 1'b1;
                  state       <= SKID_ONE;
               end
            end
            default: begin
               state     <= SKID_EMPTY;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a default instance (XLEN=64, halfword
// B/J offsets) and a companion instance (XLEN=32, byte offsets) share the
// same stimulus. Expected values are hand-computed per vector.
module tb_imm_gen_pipe;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [63:0] in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_imm;
   logic [2:0]  out_fmt;
   logic        out_illegal;
   logic [63:0] out_tag;

   logic        b_in_ready;
   logic        b_out_valid;
   logic [31:0] b_out_imm;
   logic [2:0]  b_out_fmt;
   logic        b_out_illegal;
   logic [7:0]  b_out_tag;

   int n_cmp;
   int n_bad;

   imm_gen_pipe #(
      .XLEN(64), .TAG_W(64), .BYTE_OFFSETS(0)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_imm(out_imm), .out_fmt(out_fmt),
      .out_illegal(out_illegal), .out_tag(out_tag)
   );

   imm_gen_pipe #(
      .XLEN(32), .TAG_W(8), .BYTE_OFFSETS(1)
   ) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(b_in_ready),
      .in_instr(in_instr), .in_tag(in_tag[7:0]),
      .out_valid(b_out_valid), .out_ready(out_ready),
      .out_imm(b_out_imm), .out_fmt(b_out_fmt),
      .out_illegal(b_out_illegal), .out_tag(b_out_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Offer one instruction with out_ready high; returns #1 after the accepting edge
   task automatic send(input logic [31:0] instr, input logic [63:0] tag);
      in_instr = instr;
      in_tag   = tag;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   logic [63:0] got_tags[$];
   logic [63:0] held_imm;
   logic        fire_in;
   int          stale;

   initial begin
      n_cmp     = 0;
      n_bad     = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_instr  = 32'h0;
      in_tag    = 64'h0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      check("rst_out_valid", 64'(out_valid),   64'd0);
      check("rst_in_ready",  64'(in_ready),    64'd1);
      check("rst_out_imm",   out_imm,          64'd0);
      check("rst_out_fmt",   64'(out_fmt),     64'd0);
      check("rst_illegal",   64'(out_illegal), 64'd0);
      check("rst_out_tag",   out_tag,          64'd0);
      check("rst_b_in_ready", 64'(b_in_ready), 64'd1);

      // ADDI x1, x2, -12
      send(32'hFF410093, 64'h1A5);
      check("addi_valid", 64'(out_valid),   64'd1);
      check("addi_imm",   out_imm,          64'hFFFFFFFFFFFFFFF4);
      check("addi_fmt",   64'(out_fmt),     64'd1);
      check("addi_ill",   64'(out_illegal), 64'd0);
      check("addi_tag",   out_tag,          64'h1A5);
      check("addi_b_imm", 64'(b_out_imm),   64'h00000000FFFFFFF4);
      check("addi_b_tag", 64'(b_out_tag),   64'hA5);

      // BEQ +16
      send(32'h00208863, 64'h2);
      check("beq_imm",   out_imm,        64'h0000000000000008);
      check("beq_fmt",   64'(out_fmt),   64'd3);
      check("beq_b_imm", 64'(b_out_imm), 64'h0000000000000010);

      // JAL -4
      send(32'hFFDFF06F, 64'h3);
      check("jal_imm",   out_imm,        64'hFFFFFFFFFFFFFFFE);
      check("jal_fmt",   64'(out_fmt),   64'd5);
      check("jal_b_imm", 64'(b_out_imm), 64'h00000000FFFFFFFC);

      // LUI 0x80000
      send(32'h800000B7, 64'h4);
      check("lui_imm",   out_imm,          64'hFFFFFFFF80000000);
      check("lui_fmt",   64'(out_fmt),     64'd4);
      check("lui_b_imm", 64'(b_out_imm),   64'h0000000080000000);
      check("lui_b_fmt", 64'(b_out_fmt),   64'd4);

      // SW x2, -8(x1)
      send(32'hFE20AC23, 64'h5);
      check("sw_imm", out_imm,      64'hFFFFFFFFFFFFFFF8);
      check("sw_fmt", 64'(out_fmt), 64'd2);

      // ADD x3, x1, x2 : no immediate, legal
      send(32'h002081B3, 64'h6);
      check("add_imm", out_imm,          64'd0);
      check("add_fmt", 64'(out_fmt),     64'd0);
      check("add_ill", 64'(out_illegal), 64'd0);

      // Unknown opcode
      send(32'h0000007F, 64'h7);
      check("bad_imm",   out_imm,            64'd0);
      check("bad_fmt",   64'(out_fmt),       64'd0);
      check("bad_ill",   64'(out_illegal),   64'd1);
      check("bad_b_ill", 64'(b_out_illegal), 64'd1);

      // CSRRWI x1, 0x340, 5
      send(32'h3402D0F3, 64'h8);
`ifdef IMM_GEN_PIPE_ZIMM_EN
      check("csrrwi_imm", out_imm,          64'd5);
      check("csrrwi_fmt", 64'(out_fmt),     64'd6);
      check("csrrwi_ill", 64'(out_illegal), 64'd0);
`else
      check("csrrwi_imm", out_imm,          64'd0);
      check("csrrwi_fmt", 64'(out_fmt),     64'd0);
      check("csrrwi_ill", 64'(out_illegal), 64'd1);
`endif

      // Drain, then stall the output and stream tags 1, 2, 3
      @(posedge clk);
      #1;
      check("drain_valid", 64'(out_valid), 64'd0);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'hFF410093;
      in_tag    = 64'd1;
      @(posedge clk);
      #1;
      check("bp_ready_one", 64'(in_ready), 64'd1);
      in_instr = 32'hFE20AC23;
      in_tag   = 64'd2;
      @(posedge clk);
      #1;
      check("bp_ready_two", 64'(in_ready), 64'd0);
      check("bp_tag_head",  out_tag,       64'd1);
      held_imm = out_imm;
      check("bp_imm_head",  held_imm,      64'hFFFFFFFFFFFFFFF4);
      in_instr = 32'h800000B7;
      in_tag   = 64'd3;
      repeat (3) @(posedge clk);
      #1;
      check("bp_ready_held", 64'(in_ready),  64'd0);
      check("bp_valid_held", 64'(out_valid), 64'd1);
      check("bp_tag_held",   out_tag,        64'd1);
      check("bp_imm_held",   out_imm,        held_imm);

      out_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (out_valid) got_tags.push_back(out_tag);
         fire_in = in_valid && in_ready;
         @(posedge clk);
         #1;
         if (fire_in) in_valid = 1'b0;
         if (!in_valid && !out_valid) break;
      end
      check("bp_count", 64'(got_tags.size()), 64'd3);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("bp_order%0d", k),
               (got_tags.size() > k) ? got_tags[k] : 64'hDEAD, 64'(k + 1));
      end
      check("bp_end_valid", 64'(out_valid), 64'd0);

      // Fill both entries, then reset while full
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'hFF410093;
      in_tag    = 64'h11;
      @(posedge clk);
      #1;
      in_tag = 64'h22;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("two_ready", 64'(in_ready), 64'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst2_valid", 64'(out_valid), 64'd0);
      check("rst2_ready", 64'(in_ready),  64'd1);
      check("rst2_imm",   out_imm,        64'd0);
      check("rst2_tag",   out_tag,        64'd0);
      out_ready = 1'b1;
      stale = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (out_valid) stale++;
      end
      check("rst2_no_stale", 64'(stale), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined successor to the combinational immediate generator. Decodes all RV32I/RV64I immediate formats (I, S, B, U, J) at width XLEN. Registers the result behind a valid/ready handshake with a 2-entry skid buffer. Sits between fetch/decode and the execute operand mux, and carries a sideband tag (PC or ROB id) alongside each immediate.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64; immediate sign-extended to XLEN.
TAG_W, 64, width of the sideband tag passed through unchanged.
BYTE_OFFSETS, 0, 0: B/J immediates in halfword units (offset>>1, sign-extended; branch adder applies <<1); 1: full byte offset with bit0=0.

Ports:
clk  in  1  clock, all state on rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  upstream instruction valid.
in_ready  out  1  block can accept; high when skid entry empty.
in_instr  in  32  raw instruction word.
in_tag  in  TAG_W  sideband (PC/id).
out_valid  out  1  output entry valid.
out_ready  in  1  downstream accepts.
out_imm  out  XLEN  sign-extended immediate.
out_fmt  out  3  format code (pkg enum).
out_illegal  out  1  opcode not recognised.
out_tag  out  TAG_W  tag of the instruction producing out_imm.

Behaviour:
- Reset (sync, rst=1 at edge): out_valid=0, in_ready=1 (after reset), out_imm=0, out_fmt=FMT_NONE, out_illegal=0, out_tag=0, skid entry empty. Overrides any in-flight transfer, and the entries are dropped.
- Transfer rules: input fires on in_valid&in_ready; output fires on out_valid&out_ready.
- Latency: 1 cycle from input fire to out_valid. Throughput: 1/cycle under continuous out_ready.
- Opcode map:
  - 0010011, 0000011, 1100111, 0011011 → I: instr[31:20].
  - 0100011 → S: {instr[31:25], instr[11:7]}.
  - 1100011 → B: {instr[31], instr[7], instr[30:25], instr[11:8]}.
  - 0110111, 0010111 → U: {instr[31:12], 12'b0}.
  - 1101111 → J: {instr[31], instr[19:12], instr[20], instr[30:21]}.
  - 0110011, 0111011 → FMT_NONE, imm=0, illegal=0.
  - Any other opcode → FMT_NONE, imm=0, illegal=1.
- B/J scaling: with BYTE_OFFSETS=1, B/J fields are shifted left by 1 before sign extension.
- Sign extension: all formats sign-extend from the MSB of the assembled field to XLEN. U on XLEN=64 sign-extends bit 31.
- Skid buffer states: EMPTY (out_valid=0), ONE (output reg full), TWO (output + skid full, in_ready=0).
  - EMPTY + input fire → ONE.
  - ONE + input fire, no output fire → TWO.
  - ONE + both fire → ONE (output reg reloaded).
  - ONE + output fire only → EMPTY.
  - TWO + output fire → ONE (skid entry moves into the output reg).
- Output stability: out_* stable while out_valid & !out_ready.
- Ordering: strict FIFO; no reordering or drop.
- in_ready is registered; it depends only on skid occupancy and never combinationally on out_ready.

Optional Feature:
Macro IMM_GEN_PIPE_ZIMM_EN.
- Defined: opcode 1110011 with funct3[2]=1 (CSRRWI/CSRRSI/CSRRCI) → FMT_Z, imm = zero-extended instr[19:15], illegal=0. Other 1110011 encodings → FMT_I, imm = instr[31:20] (csr number, sign-extended).
- Undefined: all 1110011 encodings → FMT_NONE, imm=0, illegal=1. FMT_Z is never emitted.

Decomposition:
- Package imm_gen_pkg holds:
  - fmt enum/localparams: FMT_NONE=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5, FMT_Z=6.
  - Opcode constants (OP_IMM, OP_LOAD, OP_JALR, OP_IMM32, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_REG, OP_REG32, OP_SYSTEM).
- One sub-module, imm_gen_decode: combinational instr → {imm, fmt, illegal}, parametrised by XLEN/BYTE_OFFSETS.
- Top module holds the skid-buffer handshake.

Test Plan:
- XLEN=64, out_ready=1, ADDI -12 (0xFF410093) → next cycle out_valid=1, out_imm=FFFFFFFFFFFFFFF4, fmt=I, illegal=0.
- BEQ +16 (0x00208863): BYTE_OFFSETS=0 → imm=0000000000000008; BYTE_OFFSETS=1 → 0000000000000010. JAL -4 (0xFFDFF06F), BYTE_OFFSETS=0 → FFFFFFFFFFFFFFFE.
- LUI 0x80000 (0x800000B7): XLEN=64 → FFFFFFFF80000000; XLEN=32 → 80000000, fmt=U.
- Backpressure: stream 3 back-to-back instrs with tags 1, 2, 3 while out_ready=0 → in_ready drops after 2 accepted; release out_ready → tags 1, 2, 3 emerge in order, none lost or duplicated, outputs held stable while stalled.
- Illegal opcode 0x0000007F → fmt=NONE, imm=0, illegal=1. CSRRWI x1, csr, 5 with macro defined → fmt=Z, imm=5; with macro undefined → illegal=1.
- Assert rst for 1 cycle while state TWO → next cycle out_valid=0, in_ready=1, out_imm=0; no stale data emerges afterwards.
